pipeline_perf_monitor: RTL

Parametrised performance monitor for the 5-stage pipeline top. It generalises the single free-running debug cycle counter into one cycle counter plus NUM_EVENTS event counters (stalls, flushes, BP mispredicts, retired instructions, ...). Counting can run free or over a programmable sampling window, with start/stop/clear control. Two selectable registered readout ports drive the top-level debug outputs (out1/out2).

---
 rtl/pipeline_perf_monitor_pkg.sv | 21 ++
 rtl/pipeline_perf_monitor_if.sv | 33 +++
 rtl/perf_counter.sv | 34 +++
 rtl/pipeline_perf_monitor.sv | 118 +++++++++++
 4 files changed

// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM encoding,
// readout select width and the channel map of pipeline events.
package pipeline_perf_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pm_state_t;

    // Readout selects are 4 bits: 0 = cycle counter, 1..15 = event channels
    localparam int SEL_WIDTH = 4;

    // Event channel assignment for the 5-stage pipeline top
    localparam int EV_FE_STALL   = 0;
    localparam int EV_DE_STALL   = 1;
    localparam int EV_BR_MISPRED = 2;
    localparam int EV_FLUSH      = 3;
    localparam int EV_RETIRE     = 4;

endpackage

// File: rtl/pipeline_perf_monitor_if.sv
// Control, event and readout bundle of the performance monitor.
// master drives events/control and observes readouts; slave is the monitor.
interface pipeline_perf_monitor_if #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int WIN_WIDTH  = 16
);
    import pipeline_perf_monitor_pkg::*;

    logic [NUM_EVENTS-1:0] event_i;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic [WIN_WIDTH-1:0]  win_len;
    logic [SEL_WIDTH-1:0]  sel_a;
    logic [SEL_WIDTH-1:0]  sel_b;
    logic [CNT_WIDTH-1:0]  out_a;
    logic [CNT_WIDTH-1:0]  out_b;
    logic                  running;
    logic                  done;
    logic [NUM_EVENTS:0]   overflow;

    modport master (
        output event_i, start, stop, clear, win_len, sel_a, sel_b,
        input  out_a, out_b, running, done, overflow
    );

    modport slave (
        input  event_i, start, stop, clear, win_len, sel_a, sel_b,
        output out_a, out_b, running, done, overflow
    );

endinterface

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear, increment strobe and a
// sticky overflow flag. SATURATE selects stick-at-all-ones or wrap.
module perf_counter #(
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] ALL_ONES = {CNT_WIDTH{1'b1}};

    // Count increments; an increment at all-ones flags overflow and saturates or wraps
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == ALL_ONES) begin
                ovf <= 1'b1;
                if (!SATURATE) begin
                    count <= '0;
                end
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor: one cycle counter plus NUM_EVENTS event counters,
// run freely or over a programmable window, with two registered readouts.
module pipeline_perf_monitor
    import pipeline_perf_monitor_pkg::*;
#(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int WIN_WIDTH  = 16,
    parameter bit SATURATE   = 1'b1,
    parameter bit AUTO_START = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_perf_monitor_if.slave bus
);

    pm_state_t             state;
    pm_state_t             state_next;
    logic [WIN_WIDTH-1:0]  win_latched;
    logic [WIN_WIDTH-1:0]  remaining;
    logic                  counting;
    logic                  expire;
    logic                  counter_clr;
    logic [NUM_EVENTS:0]   inc;
    logic [NUM_EVENTS:0]   ovf;
    logic [CNT_WIDTH-1:0]  cnt [0:NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  mux_a;
    logic [CNT_WIDTH-1:0]  mux_b;

    assign counting    = (state == RUN);
    assign expire      = counting && (win_latched != '0) && (remaining == WIN_WIDTH'(1));
    assign counter_clr = bus.clear | bus.start;

    // Slot 0 is the cycle counter; slot k+1 follows event channel k
    assign inc[0]            = counting;
    assign inc[NUM_EVENTS:1] = {NUM_EVENTS{counting}} & bus.event_i;

    assign bus.running  = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.overflow = ovf;

    // State register; AUTO_START drops straight into a free-running window
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AUTO_START ? RUN : IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: clear beats start beats stop/window expiry
    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.start) begin
            state_next = RUN;
        end else if (counting && (bus.stop || expire)) begin
            state_next = DONE;
        end
    end

    // Window length is captured on start and counted down on each RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            win_latched <= '0;
            remaining   <= '0;
        end else if (!bus.clear) begin
            if (bus.start) begin
                win_latched <= bus.win_len;
                remaining   <= bus.win_len;
            end else if (counting && (win_latched != '0)) begin
                remaining <= remaining - WIN_WIDTH'(1);
            end
        end
    end

    genvar k;
    for (k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (counter_clr),
            .inc   (inc[k]),
            .count (cnt[k]),
            .ovf   (ovf[k])
        );
    end

    // Readout selection; selects beyond the last channel read zero
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int i = 0; i <= NUM_EVENTS; i++) begin
            if (bus.sel_a == SEL_WIDTH'(i)) begin
                mux_a = cnt[i];
            end
            if (bus.sel_b == SEL_WIDTH'(i)) begin
                mux_b = cnt[i];
            end
        end
    end

    // Registered readout ports, live in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_a <= '0;
            bus.out_b <= '0;
        end else begin
            bus.out_a <= mux_a;
            bus.out_b <= mux_b;
        end
    end

endmodule
